// File: rtl/cfg_frame_writer.sv
// cfg_frame_writer: parses checksummed host frames into buffered register writes and request pulses
module cfg_frame_writer #(
  parameter int MAX_PAIRS   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  w_addr_o,
  output logic [7:0]  w_data_o,
  output logic        w_wren_o,
  output logic [10:0] req_o,
  output logic        frame_ok_o,
  output logic        frame_err_o,
  output logic [2:0]  err_code_o
);
  localparam int IW = $clog2(MAX_PAIRS + 1);
  localparam int AW = MAX_PAIRS > 1 ? $clog2(MAX_PAIRS) : 1;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_ADDR, S_DATA, S_CSUM, S_DRAIN} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_cmd, r_csum;
  logic [IW-1:0] r_len, r_idx, w_ridx;
  logic          r_bad;
  logic [15:0]   r_tmo;
  logic [7:0]    r_abuf [2**AW];
  logic [7:0]    r_dbuf [2**AW];
  logic          w_acc, w_tmo, w_burst, w_len_ok, w_ok, w_fire;
  logic [2:0]    w_err;
  assign rx_ready_o = !rst && r_state != S_DRAIN;
  assign w_acc      = rx_valid_i && rx_ready_o;
  assign w_burst    = r_cmd == 8'h01;
  assign w_tmo      = r_state inside {S_CMD, S_LEN, S_ADDR, S_DATA, S_CSUM} && r_tmo == 16'(TIMEOUT_CYC);
  assign w_len_ok   = w_burst ? rx_data_i != 8'd0 && rx_data_i <= 8'(MAX_PAIRS) : rx_data_i == 8'd0;
  // the first write of a burst is issued straight from the checksum byte, the rest from DRAIN
  assign w_ridx     = r_state == S_DRAIN ? r_idx : '0;
  assign w_fire     = (w_ok && w_burst) || (r_state == S_DRAIN && r_idx != r_len);
  // next state and frame verdict; timeout takes priority over a byte arriving the same cycle
  always_comb begin
    w_next = r_state;
    w_err  = 3'd0;
    w_ok   = 1'b0;
    if (w_tmo) begin
      w_next = S_IDLE;
      w_err  = 3'd5;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: w_next = rx_data_i == 8'hA5 ? S_CMD : S_IDLE;
        S_CMD: begin
          w_next = (rx_data_i == 8'h01 || (rx_data_i >= 8'h10 && rx_data_i <= 8'h1A)) ? S_LEN : S_IDLE;
          w_err  = w_next == S_IDLE ? 3'd2 : 3'd0;
        end
        S_LEN: begin
          w_next = !w_len_ok ? S_IDLE : w_burst ? S_ADDR : S_CSUM;
          w_err  = w_len_ok ? 3'd0 : 3'd3;
        end
        S_ADDR: w_next = S_DATA;
        S_DATA: w_next = r_idx + IW'(1) == r_len ? S_CSUM : S_ADDR;
        S_CSUM: begin
          w_err  = rx_data_i != r_csum ? 3'd1 : r_bad ? 3'd4 : 3'd0;
          w_ok   = w_err == 3'd0;
          w_next = w_ok && w_burst ? S_DRAIN : S_IDLE;
        end
        default: ;
      endcase
    end else if (r_state == S_DRAIN && r_idx == r_len) begin
      w_next = S_IDLE;
    end
  end
  // parser state register
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  // frame capture, timeout counter, pair buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd       <= '0;
      r_csum      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_bad       <= 1'b0;
      r_tmo       <= '0;
      w_addr_o    <= '0;
      w_data_o    <= '0;
      w_wren_o    <= 1'b0;
      req_o       <= '0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o  <= '0;
      for (int i = 0; i < 2**AW; i++) begin
        r_abuf[i] <= '0;
        r_dbuf[i] <= '0;
      end
    end else begin
      r_tmo       <= (w_acc || r_state == S_IDLE || r_state == S_DRAIN) ? '0 : r_tmo + 16'd1;
      frame_ok_o  <= w_ok;
      frame_err_o <= w_err != 3'd0;
      err_code_o  <= w_err != 3'd0 ? w_err : err_code_o;
      req_o       <= w_ok && !w_burst ? 11'(1) << r_cmd[3:0] : '0;
      w_wren_o    <= w_fire;
      if (w_fire) begin
        w_addr_o <= r_abuf[w_ridx[AW-1:0]];
        w_data_o <= r_dbuf[w_ridx[AW-1:0]];
        r_idx    <= w_ridx + IW'(1);
      end
      if (w_acc) begin
        case (r_state)
          S_CMD: begin
            r_cmd  <= rx_data_i;
            r_csum <= rx_data_i;
            r_bad  <= 1'b0;
          end
          S_LEN: begin
            r_len  <= rx_data_i[IW-1:0];
            r_csum <= r_csum ^ rx_data_i;
            r_idx  <= '0;
          end
          S_ADDR: begin
            r_abuf[r_idx[AW-1:0]] <= rx_data_i;
            r_csum                <= r_csum ^ rx_data_i;
            r_bad                 <= r_bad | (rx_data_i[7:4] > 4'hB);
          end
          S_DATA: begin
            r_dbuf[r_idx[AW-1:0]] <= rx_data_i;
            r_csum                <= r_csum ^ rx_data_i;
            r_idx                 <= r_idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cfg_frame_writer.sv
// tb_cfg_frame_writer: random and directed frames checked against a rule-level frame model
module tb_cfg_frame_writer;
  localparam int MP = 16;
  localparam int TO = 100;
  typedef logic [7:0] bq_t[$];
  typedef struct {int c; logic [7:0] a; logic [7:0] d;} wr_t;
  typedef struct {int c; logic [10:0] v;} ev_t;
  logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, w_wren, frame_ok, frame_err;
  logic [7:0]  w_addr, w_data;
  logic [10:0] req;
  logic [2:0]  err_code;
  int cyc = 0, n_chk = 0, n_fail = 0, last_code = 0;
  wr_t wq[$];
  ev_t rq[$], eq[$];
  int  okq[$];

  cfg_frame_writer #(.MAX_PAIRS(MP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .w_addr_o(w_addr), .w_data_o(w_data), .w_wren_o(w_wren), .req_o(req),
    .frame_ok_o(frame_ok), .frame_err_o(frame_err), .err_code_o(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    wr_t w;
    ev_t e;
    if (w_wren) begin
      w.c = cyc; w.a = w_addr; w.d = w_data;
      wq.push_back(w);
    end
    if (req != 11'd0) begin
      e.c = cyc; e.v = req;
      rq.push_back(e);
    end
    if (frame_err) begin
      e.c = cyc; e.v = 11'(err_code);
      eq.push_back(e);
    end
    if (frame_ok) okq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    wq.delete(); rq.delete(); eq.delete(); okq.delete();
  endtask

  function automatic bq_t mk_burst(input int n, input int bad_pair);
    bq_t f;
    logic [7:0] x;
    f = '{8'hA5, 8'h01, 8'(n)};
    for (int i = 0; i < n; i++) begin
      f.push_back({i == bad_pair ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)), 4'($urandom)});
      f.push_back(8'($urandom));
    end
    x = 8'h00;
    for (int j = 1; j < f.size(); j++) x ^= f[j];
    f.push_back(x);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, output int t);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", rx_ready, 1);
    t = cyc;
  endtask

  // model: verdict from frame rules, then expected events keyed to the acceptance cycle of the last byte
  task automatic run_frame(input bq_t f, input bit skip, input bit follow);
    int stop, code, tl, ta;
    logic [7:0] cmd, len, x;
    bit burst, bad;
    cmd   = f[1];
    len   = f.size() > 2 ? f[2] : 8'h00;
    burst = cmd == 8'h01;
    if (!(burst || (cmd >= 8'h10 && cmd <= 8'h1A))) begin
      code = 2; stop = 1;
    end else if (burst ? (len == 0 || len > MP) : len != 0) begin
      code = 3; stop = 2;
    end else begin
      stop = f.size() - 1;
      x = 8'h00;
      bad = 1'b0;
      for (int j = 1; j < stop; j++) x ^= f[j];
      if (burst) for (int i = 0; i < len; i++) if (f[3+2*i][7:4] > 4'hB) bad = 1'b1;
      code = x != f[stop] ? 1 : bad ? 4 : 0;
    end
    tl = 0;
    for (int i = skip ? 1 : 0; i <= stop; i++) send_byte(f[i], $urandom_range(0, 2), tl);
    if (follow) begin
      send_byte(8'hA5, 0, ta);
      check("bp_accept_cyc", ta, tl + len + 1);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (MP + 6) @(negedge clk);
    check("ok_cnt", okq.size(), code == 0);
    check("err_cnt", eq.size(), code != 0);
    if (code == 0) begin
      if (okq.size() > 0) check("ok_cyc", okq[0], tl + 1);
      check("err_hold", err_code, last_code);
      if (burst) begin
        check("wr_cnt", wq.size(), len);
        check("req_cnt", rq.size(), 0);
        for (int i = 0; i < wq.size() && i < len; i++) begin
          check("wr_cyc", wq[i].c, tl + 1 + i);
          check("wr_addr", wq[i].a, f[3+2*i]);
          check("wr_data", wq[i].d, f[4+2*i]);
        end
      end else begin
        check("wr_cnt", wq.size(), 0);
        check("req_cnt", rq.size(), 1);
        if (rq.size() > 0) begin
          check("req_cyc", rq[0].c, tl + 1);
          check("req_val", rq[0].v, 1 << (cmd - 8'h10));
        end
      end
    end else begin
      if (eq.size() > 0) begin
        check("err_cyc", eq[0].c, tl + 1);
        check("err_pulse_code", eq[0].v, code);
      end
      check("err_code", err_code, code);
      check("wr_cnt", wq.size(), 0);
      check("req_cnt", rq.size(), 0);
      last_code = code;
    end
    clear_q();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    bq_t f;
    int t0, t1, tl, kind, n, k;
    logic [7:0] c;
    repeat (3) @(negedge clk);
    check("rst_ready", rx_ready, 0);
    check("rst_wren", w_wren, 0);
    check("rst_addr", w_addr, 0);
    check("rst_data", w_data, 0);
    check("rst_req", req, 0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", rx_ready, 1);
    run_frame('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h55, 8'h85, 8'hAA, 8'h69}, 0, 0);
    run_frame('{8'hA5, 8'h14, 8'h00, 8'h14}, 0, 0);
    run_frame('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h55, 8'h85, 8'hAA, 8'h68}, 0, 0);
    run_frame('{8'hA5, 8'h01, 8'h01, 8'hC0, 8'h12, 8'hD2}, 0, 0);
    run_frame('{8'hA5, 8'h07}, 0, 0);
    run_frame('{8'hA5, 8'h01, 8'h11}, 0, 0);
    run_frame('{8'hA5, 8'h12, 8'h01}, 0, 0);
    send_byte(8'hA5, 0, t0);
    send_byte(8'h01, 0, t1);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (TO + 20) @(negedge clk);
    check("tmo_cnt", eq.size(), 1);
    if (eq.size() > 0) begin
      check("tmo_code", eq[0].v, 5);
      check("tmo_not_early", eq[0].c - t1 >= TO, 1);
    end
    check("tmo_wr_cnt", wq.size(), 0);
    check("tmo_ok_cnt", okq.size(), 0);
    clear_q();
    last_code = 5;
    run_frame('{8'hA5, 8'h01, 8'h02, 8'h10, 8'h55, 8'h85, 8'hAA, 8'h69}, 0, 0);
    run_frame(mk_burst(16, -1), 0, 1);
    run_frame('{8'hA5, 8'h14, 8'h00, 8'h14}, 1, 0);
    f = mk_burst(16, -1);
    tl = 0;
    foreach (f[i]) send_byte(f[i], 0, tl);
    @(negedge clk);
    rx_valid = 1'b0;
    while (cyc < tl + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", rx_ready, 0);
    check("mid_rst_wren", w_wren, 0);
    check("mid_rst_addr", w_addr, 0);
    check("mid_rst_data", w_data, 0);
    check("mid_rst_code", err_code, 0);
    check("mid_rst_okerr", {frame_ok, frame_err, req}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", rx_ready, 1);
    repeat (25) @(negedge clk);
    check("mid_rst_wr_cnt", wq.size(), 5);
    for (int i = 0; i < wq.size() && i < 5; i++) begin
      check("mid_rst_wr_cyc", wq[i].c, tl + 1 + i);
      check("mid_rst_wr_addr", wq[i].a, f[3+2*i]);
    end
    check("mid_rst_ok_cnt", okq.size(), 1);
    check("mid_rst_err_cnt", eq.size(), 0);
    clear_q();
    last_code = 0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 5);
      n = $urandom_range(1, MP);
      k = $urandom_range(0, 10);
      case (kind)
        0: f = mk_burst(n, -1);
        1: f = '{8'hA5, 8'(16 + k), 8'h00, 8'(16 + k)};
        2: begin
          f = mk_burst(n, -1);
          f[f.size()-1] ^= 8'(1 << $urandom_range(0, 7));
        end
        3: f = mk_burst(n, $urandom_range(0, n - 1));
        4: begin
          do c = 8'($urandom); while (c == 8'h01 || (c >= 8'h10 && c <= 8'h1A));
          f = '{8'hA5, c};
        end
        default: begin
          if ($urandom_range(0, 1) == 1) f = '{8'hA5, 8'h01, $urandom_range(0, 1) == 1 ? 8'($urandom_range(17, 255)) : 8'h00};
          else f = '{8'hA5, 8'(16 + k), 8'($urandom_range(1, 255))};
        end
      endcase
      if ($urandom_range(0, 3) == 0) begin
        c = 8'($urandom);
        if (c == 8'hA5) c = 8'h00;
        send_byte(c, 0, t0);
      end
      run_frame(f, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
